// File: rtl/csv_fifo_pkg.sv
// Shared constants and FSM state type for the FIFO write-port arbiter.
package csv_fifo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_NREQ      = 4;
  localparam int DEF_MAX_BURST = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/csv_fifo_wr_arb_if.sv
// Requester-side and FIFO-side signals of the write arbiter, grouped as one bundle.
interface csv_fifo_wr_arb_if
  import csv_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
);

  logic [NREQ-1:0]         i_req;
  logic [NREQ*WIDTH-1:0]   i_wdata;
  logic [NREQ-1:0]         i_last;
  logic [NREQ-1:0]         o_ready;
  logic                    o_wreq;
  logic [WIDTH-1:0]        o_wdata;
  logic                    i_fifo_wready;
  logic [$clog2(NREQ)-1:0] o_grant_id;
  logic                    o_busy;

  modport slave (
    input  i_req, i_wdata, i_last, i_fifo_wready,
    output o_ready, o_wreq, o_wdata, o_grant_id, o_busy
  );

  modport master (
    output i_req, i_wdata, i_last, i_fifo_wready,
    input  o_ready, o_wreq, o_wdata, o_grant_id, o_busy
  );

endinterface

// File: rtl/csv_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr, with wrap.
module csv_rr_pick
  import csv_fifo_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int IDW = $clog2(NREQ);

  int unsigned        k;
  logic [IDW-1:0]     k_idx;

  always_comb begin
    any   = 1'b0;
    idx   = '0;
    k     = 0;
    k_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k     = (32'(ptr) + i) % 32'(NREQ);
      k_idx = k[IDW-1:0];
      if (!any && req[k_idx]) begin
        any = 1'b1;
        idx = k_idx;
      end
    end
  end

endmodule

// File: rtl/csv_fifo_wr_arb.sv
// Round-robin arbiter granting one of NREQ requesters a burst of writes into a single FIFO port.
module csv_fifo_wr_arb
  import csv_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NREQ      = DEF_NREQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             reset,
  csv_fifo_wr_arb_if.slave bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic           busy;
  logic           beat;
  logic           release_now;

  csv_rr_pick #(.NREQ(NREQ)) u_pick (
    .req (bus.i_req),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign busy           = (state_q == ST_BURST);
  assign bus.o_busy     = busy;
  assign bus.o_grant_id = owner_q;

  always_comb begin
    bus.o_ready = '0;
    bus.o_wreq  = 1'b0;
    bus.o_wdata = '0;
    if (busy) begin
      bus.o_ready[owner_q] = bus.i_fifo_wready;
      bus.o_wreq           = bus.i_req[owner_q];
      bus.o_wdata          = bus.i_wdata[int'(owner_q) * WIDTH +: WIDTH];
    end
  end

  // A beat needs both the owner's valid and FIFO space; anything else is a stall.
  assign beat        = busy && bus.i_req[owner_q] && bus.i_fifo_wready;
  assign release_now = beat && (bus.i_last[owner_q] || (cnt_q + 1'b1 == CW'(MAX_BURST)));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (beat) cnt_d = cnt_q + 1'b1;
        if (release_now) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_csv_fifo_wr_arb.sv
// Scoreboard bench: requester models feed the arbiter, a monitor checks every FIFO write.
module tb_csv_fifo_wr_arb;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  csv_fifo_wr_arb_if #(.WIDTH(W), .NREQ(N)) bus ();

  csv_fifo_wr_arb #(.WIDTH(W), .NREQ(N), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] gid;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rq_data[N][32];
  logic       rq_last[N][32];
  int         head[N];
  int         tail[N];
  logic [N-1:0] en;
  logic [N-1:0] acc;
  logic       wready;
  int checks = 0;
  int errors = 0;
  int wcount = 0;
  int cyc = 0;
  int first_wr = -1;
  int last_wr = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < N; k++) begin
      if (head[k] < tail[k]) begin
        bus.i_req[k]         = en[k];
        bus.i_wdata[k*W +: W] = rq_data[k][head[k]];
        bus.i_last[k]        = rq_last[k][head[k]];
      end else begin
        bus.i_req[k]         = 1'b0;
        bus.i_wdata[k*W +: W] = '0;
        bus.i_last[k]        = 1'b0;
      end
    end
    bus.i_fifo_wready = wready;
  endtask

  task automatic load(input int k, input logic [7:0] base, input int n, input int every);
    for (int i = 0; i < n; i++) begin
      rq_data[k][tail[k]] = base + 8'(i);
      rq_last[k][tail[k]] = (every > 0) && ((i + 1) % every == 0);
      tail[k]++;
    end
  endtask

  task automatic exp_push(input int g, input logic [7:0] d);
    exp_t e;
    e.gid  = 2'(g);
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((sb.size() != 0 || bus.o_busy) && n < 400);
    chk({nm, "_drain_timeout"}, 32'(n < 400), 32'd1);
  endtask

  task automatic wait_writes(input string nm, input int target);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (wcount < target && n < 100);
    chk({nm, "_write_timeout"}, 32'(wcount >= target), 32'd1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"}, 32'(bus.o_ready), 32'd0);
    chk({nm, "_wreq"},  32'(bus.o_wreq), 32'd0);
    chk({nm, "_wdata"}, 32'(bus.o_wdata), 32'd0);
    chk({nm, "_gid"},   32'(bus.o_grant_id), 32'd0);
    chk({nm, "_busy"},  32'(bus.o_busy), 32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: any FIFO write must match the head of the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    acc = '0;
    if (!reset) begin
      acc = bus.o_ready & bus.i_req;
      if (bus.o_wreq && bus.i_fifo_wready) begin
        wcount++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=gid%0d/%0h expected=none",
                   bus.o_grant_id, bus.o_wdata);
        end else begin
          e = sb.pop_front();
          chk("wdata", 32'(bus.o_wdata), 32'(e.data));
          chk("grant_id", 32'(bus.o_grant_id), 32'(e.gid));
        end
      end
    end
  end

  // Requester models advance one beat after each accepted cycle.
  initial forever begin
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (acc[k]) head[k]++;
    drive_inputs();
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int start;
    en     = '1;
    wready = 1'b1;
    acc    = '0;
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    drive_inputs();

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #2 reset = 1'b0;

    // single requester, arbitration latency
    @(posedge clk); #2;
    load(1, 8'h11, 3, 3);
    exp_push(1, 8'h11); exp_push(1, 8'h12); exp_push(1, 8'h13);
    drive_inputs();
    @(negedge clk);
    chk("t1_arb_busy", 32'(bus.o_busy), 32'd0);
    chk("t1_arb_wreq", 32'(bus.o_wreq), 32'd0);
    @(negedge clk);
    chk("t1_busy", 32'(bus.o_busy), 32'd1);
    chk("t1_gid", 32'(bus.o_grant_id), 32'd1);
    wait_drain("t1");

    // pointer now 2: 2 before 3, then wrap to 0
    @(posedge clk); #2;
    load(3, 8'h31, 1, 1);
    load(2, 8'h21, 1, 1);
    exp_push(2, 8'h21); exp_push(3, 8'h31);
    drive_inputs();
    wait_drain("t1b");

    // all four contend, 2-beat bursts
    first_wr = -1;
    @(posedge clk); #2;
    load(0, 8'h00, 4, 2);
    load(1, 8'h10, 2, 2);
    load(2, 8'h20, 2, 2);
    load(3, 8'h30, 2, 2);
    exp_push(0, 8'h00); exp_push(0, 8'h01);
    exp_push(1, 8'h10); exp_push(1, 8'h11);
    exp_push(2, 8'h20); exp_push(2, 8'h21);
    exp_push(3, 8'h30); exp_push(3, 8'h31);
    exp_push(0, 8'h02); exp_push(0, 8'h03);
    drive_inputs();
    wait_drain("t2");
    chk("t2_span", 32'(last_wr - first_wr), 32'd13);

    // 20-beat stream cut at MAX_BURST, req3 served in between
    @(posedge clk); #2;
    load(2, 8'h40, 20, 20);
    load(3, 8'hE0, 1, 1);
    for (int i = 0; i < 16; i++) exp_push(2, 8'h40 + 8'(i));
    exp_push(3, 8'hE0);
    for (int i = 16; i < 20; i++) exp_push(2, 8'h40 + 8'(i));
    drive_inputs();
    wait_drain("t3");

    // FIFO full for 5 cycles mid-burst
    start = wcount;
    @(posedge clk); #2;
    load(3, 8'h60, 4, 4);
    for (int i = 0; i < 4; i++) exp_push(3, 8'h60 + 8'(i));
    drive_inputs();
    wait_writes("t4", start + 2);
    #2 wready = 1'b0;
    drive_inputs();
    repeat (5) begin
      @(negedge clk);
      chk("t4_ready", 32'(bus.o_ready), 32'd0);
      chk("t4_busy", 32'(bus.o_busy), 32'd1);
      chk("t4_gid", 32'(bus.o_grant_id), 32'd3);
    end
    chk("t4_no_writes", 32'(wcount), 32'(start + 2));
    @(posedge clk); #2 wready = 1'b1;
    drive_inputs();
    wait_drain("t4");

    // owner drops valid for 3 cycles while req1 waits
    start = wcount;
    @(posedge clk); #2;
    load(0, 8'h70, 4, 4);
    load(1, 8'h90, 1, 1);
    for (int i = 0; i < 4; i++) exp_push(0, 8'h70 + 8'(i));
    exp_push(1, 8'h90);
    drive_inputs();
    wait_writes("t5", start + 2);
    #2 en[0] = 1'b0;
    drive_inputs();
    repeat (3) begin
      @(negedge clk);
      chk("t5_wreq", 32'(bus.o_wreq), 32'd0);
      chk("t5_ready1", 32'(bus.o_ready[1]), 32'd0);
      chk("t5_gid", 32'(bus.o_grant_id), 32'd0);
    end
    @(posedge clk); #2 en[0] = 1'b1;
    drive_inputs();
    wait_drain("t5");

    // reset after beat 2 of a 4-beat burst
    start = wcount;
    @(posedge clk); #2;
    load(1, 8'hA0, 4, 4);
    exp_push(1, 8'hA0); exp_push(1, 8'hA1);
    drive_inputs();
    wait_writes("t6", start + 2);
    #2 reset = 1'b1;
    for (int k = 0; k < N; k++) head[k] = tail[k];
    drive_inputs();
    @(negedge clk);
    chk_all_zero("t6_reset");
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #2;
    load(3, 8'hB0, 1, 1);
    load(0, 8'hC0, 1, 1);
    exp_push(0, 8'hC0); exp_push(3, 8'hB0);
    drive_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("t6_busy", 32'(bus.o_busy), 32'd1);
    chk("t6_gid", 32'(bus.o_grant_id), 32'd0);
    wait_drain("t6");

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csv_fifo_wr_arb.md
CSV_FIFO_WR_ARB -- requirements
Module: csv_fifo_wr_arb

Interface
REQ-001 Parameter WIDTH, default 8, data width per beat, equal to the attached FIFO width.
REQ-002 Parameter NREQ, default 4, number of write requesters; legal range 2..8.
REQ-003 Parameter MAX_BURST, default 16, maximum beats per grant; legal range >= 2.
REQ-004 Port clk, input, 1, single clock; all state changes on rising edge.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port i_req, input, NREQ, per-requester write request (valid).
REQ-007 Port i_wdata, input, NREQ*WIDTH, requester k data in bits [k*WIDTH +: WIDTH].
REQ-008 Port i_last, input, NREQ, per-requester end-of-burst flag, qualified by its beat.
REQ-009 Port o_ready, output, NREQ, per-requester beat accepted this cycle.
REQ-010 Port o_wreq, output, 1, write request to FIFO.
REQ-011 Port o_wdata, output, WIDTH, write data to FIFO.
REQ-012 Port i_fifo_wready, input, 1, FIFO not full.
REQ-013 Port o_grant_id, output, $clog2(NREQ), index of current owner; valid while o_busy.
REQ-014 Port o_busy, output, 1, high in BURST state.

Function
REQ-015 FSM states: IDLE, BURST.
REQ-016 IDLE: with any i_req bit high, the block SHALL pick the first requesting index searching upward from rr_ptr with wrap, register it as owner g, and enter BURST next cycle; IDLE with no request stays IDLE.
REQ-017 Arbitration latency SHALL be exactly one cycle; in IDLE, o_ready, o_wreq and o_busy are 0.
REQ-018 BURST: o_wreq = i_req[g], o_wdata = i_wdata[g], o_ready[g] = i_fifo_wready, all other o_ready bits 0.
REQ-019 Beat = i_req[g] & i_fifo_wready; exactly one FIFO write per beat.
REQ-020 i_fifo_wready low SHALL stall: no beat, beat counter and state hold, grant held.
REQ-021 i_req[g] low mid-burst SHALL hold the grant (no beat, no release).
REQ-022 Beat counter, width $clog2(MAX_BURST+1), SHALL clear on entering BURST and increment per beat.
REQ-023 Release SHALL occur on a beat with i_last[g] high, or on the beat that makes the count equal MAX_BURST, whichever comes first; next state IDLE.
REQ-024 On release, rr_ptr SHALL become (g+1) mod NREQ, with wrap at NREQ-1 -> 0.
REQ-025 Back-to-back bursts SHALL have exactly one IDLE cycle between them.
REQ-026 Requests from non-owners during BURST SHALL be ignored and not lost; they compete at the next IDLE.
REQ-027 i_last on a non-owner, or with no beat, SHALL have no effect.

Reset
REQ-028 While reset is high: state IDLE, rr_ptr 0, beat counter 0, owner 0.
REQ-029 While reset is high: o_ready 0, o_wreq 0, o_wdata 0, o_grant_id 0, o_busy 0.
REQ-030 Reset mid-burst SHALL abort the burst with no further FIFO write; the first arbitration after release restarts at index 0.

Structure
REQ-031 A shared package csv_fifo_pkg SHALL hold the FSM state encoding localparams and the default WIDTH, NREQ and MAX_BURST constants.
REQ-032 One sub-module, csv_rr_pick, SHALL implement the combinational rotating-priority picker: inputs request vector and rr_ptr; outputs index and any.
REQ-033 The block SHALL connect directly to the FIFO write port: o_wreq -> i_wreq, o_wdata -> wdata, o_wready -> i_fifo_wready.

Verification
REQ-034 Single requester: req[1] sends 3 beats with last on beat 3 and wready=1 -> grant_id=1 one cycle after req, 3 FIFO writes, then IDLE, rr_ptr=2.
REQ-035 All 4 requesting continuously, each burst 2 beats with last -> grant order 0,1,2,3,0; one idle cycle between bursts.
REQ-036 Req[2] streams 20 beats with no last, MAX_BURST=16 -> release after beat 16; 4 remaining beats follow in a later grant.
REQ-037 Wready low for 5 cycles mid-burst -> no writes, o_ready[g]=0, count held, grant held; resumes with no data loss or duplication.
REQ-038 Reset asserted after beat 2 of a 4-beat burst -> all outputs 0 immediately; after release with req[3] and req[0] high, grant goes to 0.
REQ-039 Req[g] dropped for 3 cycles mid-burst while req[1] is high -> grant held on g; no write to req[1] until release.
